// File: rtl/rom_access_ctrl_if.sv
// CPU-side request/acknowledge bundle for the boot ROM front end.
// The master (CPU) drives the request fields; the slave (controller) returns data and status.
interface rom_access_ctrl_if;
    logic        req;
    logic [4:0]  page;
    logic [13:0] cpu_a;
    logic        flush;
    logic [7:0]  rdata;
    logic        ack;
    logic        busy;

    modport master (
        output req,
        output page,
        output cpu_a,
        output flush,
        input  rdata,
        input  ack,
        input  busy
    );

    modport slave (
        input  req,
        input  page,
        input  cpu_a,
        input  flush,
        output rdata,
        output ack,
        output busy
    );
endinterface

// File: rtl/rom_access_ctrl.sv
// Boot ROM read front end: forms the 19-bit ROM address from page/offset, times the chip
// enable for WAIT_CYC cycles and answers on a 4-phase req/ack, with a one-entry read cache.
module rom_access_ctrl #(
    parameter int WAIT_CYC = 3
) (
    input  logic               fclk,
    input  logic               rst,
    rom_access_ctrl_if.slave   cpu,
    output logic [18:0]        rom_addr,
    output logic               rom_ce_n,
    input  logic [7:0]         rom_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [18:0] rom_addr_q, rom_addr_d;
    logic        rom_ce_n_q, rom_ce_n_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        valid_q, valid_d;
    logic        poison_q, poison_d;
    logic [18:0] addr_q, addr_d;
    logic [18:0] cache_tag_q, cache_tag_d;
    logic [7:0]  cache_data_q, cache_data_d;

    logic [18:0] key;
    logic        hit;

    assign key = {cpu.page, cpu.cpu_a};
    // A flush arriving with the request forces a miss so stale data is never returned.
    assign hit = valid_q && (key == cache_tag_q) && !cpu.flush;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rom_addr_d   = rom_addr_q;
        rom_ce_n_d   = rom_ce_n_q;
        rdata_d      = rdata_q;
        ack_d        = 1'b0;
        valid_d      = valid_q;
        poison_d     = poison_q;
        addr_d       = addr_q;
        cache_tag_d  = cache_tag_q;
        cache_data_d = cache_data_q;

        if (cpu.flush) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cpu.req) begin
                    addr_d = key;
                    if (hit) begin
                        rdata_d = cache_data_q;
                        ack_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rom_addr_d = key;
                        rom_ce_n_d = 1'b0;
                        cnt_d      = CNT_INIT;
                        poison_d   = 1'b0;
                        state_d    = ACCESS;
                    end
                end
            end

            ACCESS: begin
                // Poison marks the in-flight fill as stale; it still completes and returns data.
                if (cpu.flush) begin
                    poison_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    rdata_d      = rom_data;
                    cache_data_d = rom_data;
                    cache_tag_d  = addr_q;
                    valid_d      = !(poison_q || cpu.flush);
                    rom_ce_n_d   = 1'b1;
                    ack_d        = cpu.req;
                    state_d      = cpu.req ? DONE : IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            DONE: begin
                if (!cpu.req) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rom_addr_q <= 19'd0;
            rom_ce_n_q <= 1'b1;
            rdata_q    <= 8'd0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            poison_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            rom_ce_n_q <= rom_ce_n_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            poison_q   <= poison_d;
        end
    end

    // Tag/data storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge fclk) begin
        addr_q       <= addr_d;
        cache_tag_q  <= cache_tag_d;
        cache_data_q <= cache_data_d;
    end

    assign rom_addr  = rom_addr_q;
    assign rom_ce_n  = rom_ce_n_q;
    assign cpu.rdata = rdata_q;
    assign cpu.ack   = ack_q;
    assign cpu.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rom_access_ctrl.sv
// Directed bench for rom_access_ctrl: miss/hit latency, page keying, abort, flush
// poisoning and asynchronous reset, with a behavioural ROM driving rom_data.
module tb_rom_access_ctrl;

    logic        fclk = 1'b0;
    logic        rst  = 1'b0;
    logic [18:0] rom_addr;
    logic        rom_ce_n;
    wire  [7:0]  rom_data;

    int n_cmp = 0;
    int n_bad = 0;

    rom_access_ctrl_if bus();

    rom_access_ctrl #(.WAIT_CYC(3)) dut (
        .fclk     (fclk),
        .rst      (rst),
        .cpu      (bus),
        .rom_addr (rom_addr),
        .rom_ce_n (rom_ce_n),
        .rom_data (rom_data)
    );

    always #5 fclk = ~fclk;

    function automatic logic [7:0] rom_byte(input logic [18:0] a);
        if (a == 19'h00000)      return 8'hF3;
        else if (a == 19'h04000) return 8'hAA;
        else                     return a[7:0] ^ 8'h5A;
    endfunction

    assign rom_data = rom_ce_n ? 8'hzz : rom_byte(rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: plain read; 1: flush raised together with req; 2: flush pulsed in ACCESS
    task automatic do_read(input string tag, input logic [4:0] pg, input logic [13:0] a,
                           input int mode, input logic [7:0] exp_d, input int exp_lat,
                           input int exp_ce, input logic [18:0] exp_addr);
        int          edges;
        int          ce_cnt;
        logic        seen;
        logic        addr_bad;
        logic [18:0] addr_seen;
        edges = 0; ce_cnt = 0; seen = 1'b0; addr_bad = 1'b0; addr_seen = '0;
        bus.req = 1'b1; bus.page = pg; bus.cpu_a = a;
        bus.flush = (mode == 1);
        while (!seen && edges < 20) begin
            @(negedge fclk);
            edges++;
            if (edges == 1) bus.flush = (mode == 2);
            if (edges == 2) bus.flush = 1'b0;
            if (!rom_ce_n) begin
                if (ce_cnt == 0) addr_seen = rom_addr;
                else if (rom_addr !== addr_seen) addr_bad = 1'b1;
                ce_cnt++;
            end
            if (bus.ack === 1'b1) seen = 1'b1;
        end
        bus.flush = 1'b0;
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        check({tag, "_ce_cycles"}, 32'(ce_cnt), 32'(exp_ce));
        check({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_d));
        if (exp_ce > 0) begin
            check({tag, "_rom_addr"}, 32'(addr_seen), 32'(exp_addr));
            check({tag, "_addr_stable"}, 32'(addr_bad), 32'd0);
        end
        bus.req = 1'b0;
        @(negedge fclk);
        check({tag, "_ack_single"}, 32'(bus.ack), 32'd0);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int lows;
        int acks;
        bus.req = 1'b0; bus.page = '0; bus.cpu_a = '0; bus.flush = 1'b0;

        // Reset values
        #1 rst = 1'b1;
        @(negedge fclk);
        @(negedge fclk);
        check("rst_ce_n", 32'(rom_ce_n), 32'd1);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge fclk);

        // 1: cold miss, 2: hit on repeat
        do_read("t1_miss", 5'd0, 14'h0000, 0, 8'hF3, 4, 3, 19'h00000);
        do_read("t2_hit", 5'd0, 14'h0000, 0, 8'hF3, 1, 0, 19'h00000);

        // 3: same offset on another page misses, and evicts the page-0 entry
        do_read("t3_page1", 5'd1, 14'h0000, 0, 8'hAA, 4, 3, 19'h04000);
        do_read("t3_reread0", 5'd0, 14'h0000, 0, 8'hF3, 4, 3, 19'h00000);

        // 4: abort one cycle into ACCESS
        bus.req = 1'b1; bus.page = 5'd2; bus.cpu_a = 14'h0123;
        @(negedge fclk);
        check("t4_ce_low", 32'(rom_ce_n), 32'd0);
        check("t4_busy", 32'(bus.busy), 32'd1);
        bus.req = 1'b0;
        lows = 1; acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge fclk);
            if (!rom_ce_n) lows++;
            if (bus.ack === 1'b1) acks++;
        end
        check("t4_ce_cycles", 32'(lows), 32'd3);
        check("t4_no_ack", 32'(acks), 32'd0);
        check("t4_busy_after", 32'(bus.busy), 32'd0);
        do_read("t4_hit", 5'd2, 14'h0123, 0, 8'h79, 1, 0, 19'h08123);

        // 5: flush during ACCESS poisons the fill
        do_read("t5_flush_acc", 5'd3, 14'h3FFF, 2, 8'hA5, 4, 3, 19'h0FFFF);
        do_read("t5_repeat", 5'd3, 14'h3FFF, 0, 8'hA5, 4, 3, 19'h0FFFF);
        do_read("t5_flush_req", 5'd3, 14'h3FFF, 1, 8'hA5, 4, 3, 19'h0FFFF);
        do_read("t5_hit_after", 5'd3, 14'h3FFF, 0, 8'hA5, 1, 0, 19'h0FFFF);

        // 6: asynchronous reset while the ROM is enabled
        bus.req = 1'b1; bus.page = 5'd0; bus.cpu_a = 14'h0010;
        @(negedge fclk);
        check("t6_ce_low", 32'(rom_ce_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t6_async_ce_n", 32'(rom_ce_n), 32'd1);
        check("t6_async_ack", 32'(bus.ack), 32'd0);
        check("t6_async_busy", 32'(bus.busy), 32'd0);
        bus.req = 1'b0;
        @(negedge fclk);
        rst = 1'b0;
        @(negedge fclk);
        do_read("t6_post_miss", 5'd0, 14'h0000, 0, 8'hF3, 4, 3, 19'h00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
